// File: rtl/sensor_poll_pkg.sv
// Shared constants for the sensor poll scheduler: FSM state codes, result status codes, default check key.
// Latency: none (declarations only).
// Backpressure: not applicable.
package sensor_poll_pkg;

   // FSM state codes
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SEND    = 3'd1;
   localparam logic [2:0] S_WAIT_TX = 3'd2;
   localparam logic [2:0] S_WAIT_B0 = 3'd3;
   localparam logic [2:0] S_WAIT_B1 = 3'd4;
   localparam logic [2:0] S_CHECK   = 3'd5;
   localparam logic [2:0] S_DONE    = 3'd6;

   // Result status codes, also stored in the per-sensor table
   localparam logic [1:0] ST_OK        = 2'b00;
   localparam logic [1:0] ST_TIMEOUT   = 2'b01;
   localparam logic [1:0] ST_CHECK_ERR = 2'b10;

   localparam logic [7:0] DEF_CHECK_KEY = 8'h37;

   // A reply is good when the check byte is the data byte XORed with the key
   function automatic logic [1:0] check_status(input logic [7:0] data,
                                               input logic [7:0] check,
                                               input logic [7:0] key);
      return (check == (data ^ key)) ? ST_OK : ST_CHECK_ERR;
   endfunction

endpackage

// File: rtl/sensor_poll_scheduler_timeout_counter.sv
// Counts cycles elapsed since a clear cycle and flags when TERMINAL cycles have elapsed.
// Latency: the clear cycle counts as cycle 0; o_expire is combinational in cycle TERMINAL-1 after clear.
// Backpressure: none; the counter saturates at its terminal value until the next clear.
module timeout_counter #(
   parameter int TERMINAL = 100
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam int CW = (TERMINAL > 2) ? $clog2(TERMINAL) : 1;
   localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

   logic [CW-1:0] r_cnt;

   // A clear that is also enabled counts its own cycle, so the count equals cycles since clear
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= i_enable ? CW'(1) : '0;
      end else if (i_enable && (r_cnt != LAST)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Stale counts from a previous window must not fire during the clear cycle
   assign o_expire = i_enable && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Arbitrates host and round-robin poll requests onto one UART link, validates replies, keeps a per-sensor table.
// Latency: host_req accepted at T -> tx_dv at T+1; second reply byte at R -> res_valid at R+2.
// Backpressure: one transaction in flight; host_req is only sampled in IDLE, polls wait for the gap counter.
module sensor_poll_scheduler
   import sensor_poll_pkg::*;
#(
   parameter int         NUM_SENSORS    = 8,
   parameter int         TIMEOUT_CYCLES = 500_000_000,
   parameter int         GAP_CYCLES     = 1000,
   parameter logic [7:0] CHECK_KEY      = DEF_CHECK_KEY
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_poll_en,
   input  logic       i_host_req,
   input  logic [7:0] i_host_sensor,
   output logic       o_host_ack,
   output logic       o_tx_dv,
   output logic [7:0] o_tx_byte,
   input  logic       i_tx_done,
   input  logic       i_rx_dv,
   input  logic [7:0] i_rx_byte,
   output logic       o_res_valid,
   output logic [7:0] o_res_sensor,
   output logic [7:0] o_res_data,
   output logic [1:0] o_res_status,
   output logic       o_res_host,
   input  logic [4:0] i_rd_addr,
   output logic [9:0] o_rd_data,
   output logic       o_busy
);

   localparam int PTR_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;
   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_SENSORS - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

   logic [2:0]       r_state;
   logic [PTR_W-1:0] r_ptr;
   logic [GAP_W-1:0] r_gap;
   logic [7:0]       r_addr;
   logic             r_host;
   logic [7:0]       r_data;
   logic [7:0]       r_check;
   logic             r_tx_dv;
   logic [7:0]       r_tx_byte;
   logic             r_host_ack;
   logic             r_res_valid;
   logic [7:0]       r_res_sensor;
   logic [7:0]       r_res_data;
   logic [1:0]       r_res_status;
   logic             r_res_host;
   logic [7:0]       r_tab_dat [NUM_SENSORS];
   logic [1:0]       r_tab_st  [NUM_SENSORS];

   logic w_to_clear;
   logic w_to_en;
   logic w_expire;
   logic w_wr_en;
   logic w_rd_hit;

   // The reply window opens in the tx_done cycle and runs through both reply bytes
   assign w_to_clear = (r_state == S_WAIT_TX) && i_tx_done;
   assign w_to_en    = w_to_clear || (r_state == S_WAIT_B0) || (r_state == S_WAIT_B1);

   timeout_counter #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timeout (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_clear  (w_to_clear),
      .i_enable (w_to_en),
      .o_expire (w_expire)
   );

   // Transaction sequencer: arbitration, request, reply collection, result reporting
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_gap        <= '0;
         r_addr       <= '0;
         r_host       <= 1'b0;
         r_data       <= '0;
         r_check      <= '0;
         r_tx_dv      <= 1'b0;
         r_tx_byte    <= '0;
         r_host_ack   <= 1'b0;
         r_res_valid  <= 1'b0;
         r_res_sensor <= '0;
         r_res_data   <= '0;
         r_res_status <= '0;
         r_res_host   <= 1'b0;
      end else begin
         r_tx_dv     <= 1'b0;
         r_host_ack  <= 1'b0;
         r_res_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_gap != '0) r_gap <= r_gap - 1'b1;
               if (i_host_req) begin
                  r_addr     <= i_host_sensor;
                  r_tx_byte  <= i_host_sensor;
                  r_host     <= 1'b1;
                  r_host_ack <= 1'b1;
                  r_tx_dv    <= 1'b1;
                  r_state    <= S_SEND;
               end else if (i_poll_en && (r_gap == '0)) begin
                  r_addr     <= 8'(r_ptr);
                  r_tx_byte  <= 8'(r_ptr);
                  r_host     <= 1'b0;
                  r_tx_dv    <= 1'b1;
                  r_state    <= S_SEND;
               end
            end
            S_SEND: r_state <= S_WAIT_TX;
            S_WAIT_TX: if (i_tx_done) r_state <= S_WAIT_B0;
            S_WAIT_B0, S_WAIT_B1: begin
               // A byte arriving in the expiry cycle still counts
               if (i_rx_dv) begin
                  if (r_state == S_WAIT_B0) begin
                     r_data  <= i_rx_byte;
                     r_state <= S_WAIT_B1;
                  end else begin
                     r_check <= i_rx_byte;
                     r_state <= S_CHECK;
                  end
               end else if (w_expire) begin
                  r_res_valid  <= 1'b1;
                  r_res_sensor <= r_addr;
                  r_res_data   <= 8'h00;
                  r_res_status <= ST_TIMEOUT;
                  r_res_host   <= r_host;
                  r_state      <= S_DONE;
               end
            end
            S_CHECK: begin
               r_res_valid  <= 1'b1;
               r_res_sensor <= r_addr;
               r_res_data   <= r_data;
               r_res_status <= check_status(r_data, r_check, CHECK_KEY);
               r_res_host   <= r_host;
               r_state      <= S_DONE;
            end
            S_DONE: begin
               if (!r_host) r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
               r_gap   <= GAP_LOAD;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Out-of-range host addresses are reported but never stored
   assign w_wr_en  = (r_state == S_DONE) && (r_res_sensor < 8'(NUM_SENSORS));
   assign w_rd_hit = ({3'b000, i_rd_addr} < 8'(NUM_SENSORS));

   // Per-sensor table of the latest value and status; entries start as timed out
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         for (int i = 0; i < NUM_SENSORS; i++) begin
            r_tab_dat[i] <= 8'h00;
            r_tab_st[i]  <= ST_TIMEOUT;
         end
      end else if (w_wr_en) begin
         r_tab_dat[r_res_sensor[PTR_W-1:0]] <= r_res_data;
         r_tab_st[r_res_sensor[PTR_W-1:0]]  <= r_res_status;
      end
   end

   assign o_rd_data    = w_rd_hit ? {r_tab_st[i_rd_addr[PTR_W-1:0]], r_tab_dat[i_rd_addr[PTR_W-1:0]]} : 10'h000;
   assign o_busy       = (r_state != S_IDLE);
   assign o_host_ack   = r_host_ack;
   assign o_tx_dv      = r_tx_dv;
   assign o_tx_byte    = r_tx_byte;
   assign o_res_valid  = r_res_valid;
   assign o_res_sensor = r_res_sensor;
   assign o_res_data   = r_res_data;
   assign o_res_status = r_res_status;
   assign o_res_host   = r_res_host;

endmodule
